// File: rtl/audio_dac_serializer_if.sv
// Sample handshake between the filter stage and the DAC serializer.
// The filter drives a {left, right} word with valid; the serializer answers with ready.
interface audio_dac_serializer_if #(
    parameter int DATA_W = 16
);
    logic [2*DATA_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_dac_serializer.sv
// Serializes {left, right} stereo words onto AUD_DACDAT for a codec that masters BCLK/LRCK.
// Codec pins are oversampled in the clk domain; actions happen only on detected BCLK falls.
//
//  state | meaning
//  IDLE  | after reset, AUD_DACDAT held 0 until the first LRCK 1->0
//  LEFT  | sending the left half of the current word
//  RIGHT | sending the right half of the current word
module audio_dac_serializer #(
    parameter int DATA_W      = 16,
    parameter int I2S_DELAY   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   AUD_BCLK,
    input  logic                   AUD_DACLRCK,
    audio_dac_serializer_if.slave  smp,
    output logic                   AUD_DACDAT,
    output logic                   frame_start,
    output logic                   underrun
);
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    localparam logic [6:0] K_FIRST = 7'(1 + I2S_DELAY);
    localparam logic [6:0] K_END   = 7'(DATA_W + 1 + I2S_DELAY);

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
    logic                   bclk_prev, lr_prev, lr_prev_nxt;
    logic                   bclk_s, lrck_s, fall, left_start, xfer;
    logic [2*DATA_W-1:0]    hold_q, word_q, word_nxt;
    logic                   hold_full, hold_full_nxt;
    logic [5:0]             bit_cnt, bit_cnt_nxt;
    logic [6:0]             cnt_ext, shamt;
    logic [DATA_W-1:0]      half, half_sh;
    logic                   dacdat_nxt;

    assign bclk_s     = bclk_sync[SYNC_STAGES-1];
    assign lrck_s     = lrck_sync[SYNC_STAGES-1];
    assign fall       = bclk_prev & ~bclk_s;
    assign left_start = fall & lr_prev & ~lrck_s;

    assign smp.sample_ready = ~hold_full;
    assign xfer             = smp.sample_valid & ~hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        hold_full_nxt = hold_full;
        bit_cnt_nxt   = bit_cnt;
        word_nxt      = word_q;
        lr_prev_nxt   = lr_prev;
        dacdat_nxt    = AUD_DACDAT;
        frame_start   = 1'b0;
        underrun      = 1'b0;
        half          = '0;
        cnt_ext       = '0;
        shamt         = '0;
        half_sh       = '0;

        if (xfer) hold_full_nxt = 1'b1;

        if (fall) begin
            lr_prev_nxt = lrck_s;
            if (lrck_s != lr_prev)     bit_cnt_nxt = 6'd1;
            else if (bit_cnt != 6'd63) bit_cnt_nxt = bit_cnt + 6'd1;

            // A word handed over in this same clk stays in the holding register for the next frame.
            if (left_start) begin
                frame_start = 1'b1;
                state_nxt   = LEFT;
                if (hold_full) begin
                    word_nxt      = hold_q;
                    hold_full_nxt = 1'b0;
                end else begin
                    word_nxt = '0;
                    underrun = 1'b1;
                end
            end else if (state == LEFT && lrck_s) begin
                state_nxt = RIGHT;
            end

            half    = (state_nxt == RIGHT) ? word_nxt[DATA_W-1:0] : word_nxt[2*DATA_W-1:DATA_W];
            cnt_ext = {1'b0, bit_cnt_nxt};
            shamt   = cnt_ext - K_FIRST;
            half_sh = half << shamt;
            if (state_nxt != IDLE && cnt_ext >= K_FIRST && cnt_ext < K_END)
                dacdat_nxt = half_sh[DATA_W-1];
            else
                dacdat_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            bclk_prev  <= 1'b0;
            lr_prev    <= 1'b0;
            hold_q     <= '0;
            hold_full  <= 1'b0;
            word_q     <= '0;
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
            bclk_prev  <= bclk_s;
            lr_prev    <= lr_prev_nxt;
            if (xfer) hold_q <= smp.sample_in;
            hold_full  <= hold_full_nxt;
            word_q     <= word_nxt;
            bit_cnt    <= bit_cnt_nxt;
            AUD_DACDAT <= dacdat_nxt;
        end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench: an I2S instance and a left-justified instance share the codec pins and sample stream.
module tb_audio_dac_serializer;
    logic clk = 1'b0;
    logic rst;
    logic AUD_BCLK, AUD_DACLRCK;
    logic dacdat1, dacdat0, fs1, fs0, ur1, ur0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_fs_cyc = 0;
    logic prev1 = 1'b0;
    logic prev0 = 1'b0;

    audio_dac_serializer_if #(.DATA_W(16)) sif1 ();
    audio_dac_serializer_if #(.DATA_W(16)) sif0 ();

    audio_dac_serializer #(.DATA_W(16), .I2S_DELAY(1), .SYNC_STAGES(2)) dut_i2s (
        .clk(clk), .rst(rst), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .smp(sif1),
        .AUD_DACDAT(dacdat1), .frame_start(fs1), .underrun(ur1));

    audio_dac_serializer #(.DATA_W(16), .I2S_DELAY(0), .SYNC_STAGES(2)) dut_lj (
        .clk(clk), .rst(rst), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .smp(sif0),
        .AUD_DACDAT(dacdat0), .frame_start(fs0), .underrun(ur0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic bitx(input logic [15:0] h, input int k, input int d);
        int p;
        p = k - 1 - d;
        if (p >= 0 && p < 16) return h[15-p];
        return 1'b0;
    endfunction

    task automatic set_in(input logic [31:0] w, input logic v);
        sif1.sample_in = w; sif1.sample_valid = v;
        sif0.sample_in = w; sif0.sample_valid = v;
    endtask

    task automatic push(input logic [31:0] w, output int acc);
        int n;
        n = 0;
        set_in(w, 1'b1);
        while (sif1.sample_ready !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL push_timeout: ready got %b want 1 within 3000 clk", sif1.sample_ready);
        end
        acc = cyc;
        @(posedge clk); #1;
        set_in(w, 1'b0);
    endtask

    // One BCLK period (16 clk): pin fall with LRCK=lr, output checked 2 clk (old) and 3 clk (new) later.
    task automatic fall(input string tag, input logic lr, input logic e1, input logic e0,
                        input logic fs, input logic ur, input logic late_en, input logic [31:0] late_w);
        AUD_BCLK = 1'b0; AUD_DACLRCK = lr;
        if (fs) last_fs_cyc = cyc;
        @(posedge clk); #1;
        tests++;
        if (fs1 !== 1'b0) begin fails++; $display("FAIL %s early_frame_start: got %b want 0", tag, fs1); end
        @(posedge clk); #1;
        tests += 6;
        if (dacdat1 !== prev1) begin fails++; $display("FAIL %s latency_i2s: got %b want %b", tag, dacdat1, prev1); end
        if (dacdat0 !== prev0) begin fails++; $display("FAIL %s latency_lj: got %b want %b", tag, dacdat0, prev0); end
        if (fs1 !== fs) begin fails++; $display("FAIL %s frame_start_i2s: got %b want %b", tag, fs1, fs); end
        if (fs0 !== fs) begin fails++; $display("FAIL %s frame_start_lj: got %b want %b", tag, fs0, fs); end
        if (ur1 !== ur) begin fails++; $display("FAIL %s underrun_i2s: got %b want %b", tag, ur1, ur); end
        if (ur0 !== ur) begin fails++; $display("FAIL %s underrun_lj: got %b want %b", tag, ur0, ur); end
        if (late_en) set_in(late_w, 1'b1);
        @(posedge clk); #1;
        if (late_en) begin
            set_in(late_w, 1'b0);
            tests++;
            if (sif1.sample_ready !== 1'b0) begin fails++; $display("FAIL %s late_accept: ready got %b want 0", tag, sif1.sample_ready); end
        end
        tests += 3;
        if (dacdat1 !== e1) begin fails++; $display("FAIL %s bit_i2s: got %b want %b", tag, dacdat1, e1); end
        if (dacdat0 !== e0) begin fails++; $display("FAIL %s bit_lj: got %b want %b", tag, dacdat0, e0); end
        if (fs1 !== 1'b0) begin fails++; $display("FAIL %s frame_start_width: got %b want 0", tag, fs1); end
        prev1 = e1; prev0 = e0;
        repeat (5) @(posedge clk); #1;
        AUD_BCLK = 1'b1;
        repeat (8) @(posedge clk); #1;
    endtask

    task automatic play_frame(input string tag, input logic [31:0] w, input logic ur, input int lf, input int rf,
                              input logic late_en, input logic [31:0] late_w);
        for (int k = 1; k <= lf; k++)
            fall(tag, 1'b0, bitx(w[31:16], k, 1), bitx(w[31:16], k, 0), k == 1, (k == 1) && ur,
                 late_en && (k == 1), late_w);
        for (int k = 1; k <= rf; k++)
            fall(tag, 1'b1, bitx(w[15:0], k, 1), bitx(w[15:0], k, 0), 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0; AUD_BCLK = 1'b1; AUD_DACLRCK = 1'b0; set_in(32'h0, 1'b0);
        repeat (3) @(posedge clk); #1;
        tests += 5;
        if (sif1.sample_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", sif1.sample_ready); end
        if (dacdat1 !== 1'b0) begin fails++; $display("FAIL reset_dacdat_i2s: got %b want 0", dacdat1); end
        if (dacdat0 !== 1'b0) begin fails++; $display("FAIL reset_dacdat_lj: got %b want 0", dacdat0); end
        if (fs1 !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b want 0", fs1); end
        if (ur1 !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b want 0", ur1); end
        for (int i = 0; i < 4; i++) fall("reset_held", i[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        repeat (8) @(posedge clk); #1;
        for (int i = 0; i < 3; i++) fall("idle_lr0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) fall("idle_lr1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_i2s_frame();
        int acc;
        push(32'hA5A5_3C3C, acc);
        tests++;
        if (sif1.sample_ready !== 1'b0) begin fails++; $display("FAIL i2s_ready_drop: got %b want 0", sif1.sample_ready); end
        play_frame("i2s_frame", 32'hA5A5_3C3C, 1'b0, 20, 20, 1'b0, 32'h0);
    endtask

    task automatic test_left_justified();
        int acc;
        push(32'h8001_7FFE, acc);
        play_frame("left_just", 32'h8001_7FFE, 1'b0, 18, 18, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b, fs_a;
        fork
            begin
                play_frame("bp_first", 32'h1111_2222, 1'b0, 20, 20, 1'b0, 32'h0);
                fs_a = last_fs_cyc;
                play_frame("bp_second", 32'h3333_4444, 1'b0, 20, 20, 1'b0, 32'h0);
            end
            begin
                push(32'h1111_2222, acc_a);
                tests++;
                if (sif1.sample_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_drop: got %b want 0", sif1.sample_ready); end
                push(32'h3333_4444, acc_b);
            end
        join
        tests++;
        if (acc_b !== fs_a + 3) begin fails++; $display("FAIL bp_accept_cycle: got %0d want %0d", acc_b, fs_a + 3); end
    endtask

    task automatic test_underrun();
        int acc;
        play_frame("underrun", 32'h0, 1'b1, 20, 20, 1'b0, 32'h0);
        play_frame("late_word", 32'h0, 1'b1, 20, 20, 1'b1, 32'hC3C3_5A5A);
        play_frame("late_play", 32'hC3C3_5A5A, 1'b0, 20, 20, 1'b0, 32'h0);
    endtask

    task automatic test_truncation();
        int acc;
        push(32'hF0F0_9669, acc);
        play_frame("trunc_long", 32'hF0F0_9669, 1'b0, 10, 70, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        int acc;
        push(32'hFFFF_FFFF, acc);
        play_frame("pre_reset", 32'hFFFF_FFFF, 1'b0, 20, 5, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        tests += 4;
        if (dacdat1 !== 1'b0) begin fails++; $display("FAIL midrst_dacdat_i2s: got %b want 0", dacdat1); end
        if (dacdat0 !== 1'b0) begin fails++; $display("FAIL midrst_dacdat_lj: got %b want 0", dacdat0); end
        if (sif1.sample_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", sif1.sample_ready); end
        if (fs1 !== 1'b0) begin fails++; $display("FAIL midrst_frame_start: got %b want 0", fs1); end
        prev1 = 1'b0; prev0 = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) @(posedge clk); #1;
        for (int i = 0; i < 3; i++) fall("post_reset_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        push(32'h0F0F_F00F, acc);
        play_frame("post_reset", 32'h0F0F_F00F, 1'b0, 20, 20, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_i2s_frame();
        test_left_justified();
        test_back_to_back();
        test_underrun();
        test_truncation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
